vga_pixel_serializer: RTL and testbench

Parametrised pixel serializer for the VGA text path, the successor of the fixed 10-bit shift register. It takes one font row per character cell (FONT_W glyph bits plus GAP_W blank inter-character bits) and emits one pixel per pixel-clock enable. Each pixel comes out as a foreground/background colour. The block adds per-cell cursor inversion, optional double-width pixel replication, and a load-request strobe so the character fetch logic can keep the cells gapless. It sits between the font ROM read stage and the VGA colour output register.

---
 rtl/vga_pkg.sv | 13 +
 rtl/vga_pix_rep_cnt.sv | 47 ++++
 rtl/vga_pixel_serializer.sv | 101 ++++++++++
 tb/tb_vga_pixel_serializer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared defaults and state encoding for the VGA text pixel path
package vga_pkg;

  localparam int FONT_W_DEF = 8;
  localparam int GAP_W_DEF  = 2;
  localparam int CW_DEF     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/vga_pix_rep_cnt.sv
// rtl/vga_pix_rep_cnt.sv - pixel/repetition counter pair: shift enable and last-cycle flag
module vga_pix_rep_cnt #(
  parameter int CELL_W = 10
) (
  input  logic i_clk,
  input  logic i_rst_l,
  input  logic i_cs_h,
  input  logic i_ld_h,
  input  logic i_run_h,
  input  logic i_dbl_h,
  output logic o_shift_h,
  output logic o_last_h
);

  localparam int PCW = (CELL_W > 1) ? $clog2(CELL_W) : 1;

  logic [PCW-1:0] pix_cnt;
  logic           rep_cnt;
  logic           adv;
  logic           rep_hold;
  logic           at_end;

  assign adv       = i_run_h & i_cs_h & ~i_ld_h;
  // First half of a double-width pixel: hold the shift register.
  assign rep_hold  = i_dbl_h & ~rep_cnt;
  assign at_end    = (pix_cnt == PCW'(CELL_W - 1));
  assign o_shift_h = adv & ~rep_hold;
  assign o_last_h  = i_run_h & i_cs_h & at_end & ~rep_hold;

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      pix_cnt <= '0;
      rep_cnt <= 1'b0;
    end else if (i_cs_h & i_ld_h) begin
      pix_cnt <= '0;
      rep_cnt <= 1'b0;
    end else if (adv) begin
      if (rep_hold) begin
        rep_cnt <= 1'b1;
      end else begin
        rep_cnt <= 1'b0;
        pix_cnt <= at_end ? '0 : pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_pixel_serializer.sv
// rtl/vga_pixel_serializer.sv - font row to fg/bg pixel serializer with cursor inverse and double width
module vga_pixel_serializer
  import vga_pkg::*;
#(
  parameter int FONT_W = FONT_W_DEF,
  parameter int GAP_W  = GAP_W_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_l,
  input  logic              i_cs_h,
  input  logic              i_ld_h,
  input  logic [FONT_W-1:0] i_data,
  input  logic [CW-1:0]     i_fg,
  input  logic [CW-1:0]     i_bg,
  input  logic              i_inv_h,
  input  logic              i_dbl_h,
  output logic              o_req_h,
  output logic              o_pix_h,
  output logic [CW-1:0]     o_rgb,
  output logic              o_busy_h
);

  localparam int CELL_W = FONT_W + GAP_W;

  state_t            state_q;
  state_t            state_d;
  logic [CELL_W-1:0] shreg;
  logic [CELL_W-1:0] load_val;
  logic [CW-1:0]     fg_q;
  logic [CW-1:0]     bg_q;
  logic              inv_q;
  logic              dbl_q;
  logic              load;
  logic              run;
  logic              shift_en;
  logic              last_px;
  logic              active;
  logic              pix_on;

  assign load     = i_cs_h & i_ld_h;
  assign run      = (state_q == ST_RUN);
  // Glyph left-aligned, gap columns zero-filled on the right.
  assign load_val = CELL_W'(i_data) << GAP_W;

  vga_pix_rep_cnt #(
    .CELL_W (CELL_W)
  ) u_cnt (
    .i_clk     (i_clk),
    .i_rst_l   (i_rst_l),
    .i_cs_h    (i_cs_h),
    .i_ld_h    (i_ld_h),
    .i_run_h   (run),
    .i_dbl_h   (dbl_q),
    .o_shift_h (shift_en),
    .o_last_h  (last_px)
  );

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_RUN;
    end else if (last_px) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      shreg <= '0;
      fg_q  <= '0;
      bg_q  <= '0;
      inv_q <= 1'b0;
      dbl_q <= 1'b0;
    end else if (load) begin
      shreg <= load_val;
      fg_q  <= i_fg;
      bg_q  <= i_bg;
      inv_q <= i_inv_h;
      dbl_q <= i_dbl_h;
    end else if (shift_en) begin
      shreg <= shreg << 1;
    end
  end

  assign active   = run & i_cs_h;
  assign pix_on   = shreg[CELL_W-1] ^ inv_q;
  assign o_busy_h = active;
  assign o_pix_h  = active & pix_on;
  assign o_rgb    = active ? (pix_on ? fg_q : bg_q) : '0;
  assign o_req_h  = last_px;

endmodule

// File: tb/tb_vga_pixel_serializer.sv
// tb/tb_vga_pixel_serializer.sv - scoreboard bench for vga_pixel_serializer
module tb_vga_pixel_serializer;

  localparam int FONT_W = 8;
  localparam int GAP_W  = 2;
  localparam int CW     = 4;
  localparam int CELL_W = FONT_W + GAP_W;

  logic              i_clk;
  logic              i_rst_l;
  logic              i_cs_h;
  logic              i_ld_h;
  logic [FONT_W-1:0] i_data;
  logic [CW-1:0]     i_fg;
  logic [CW-1:0]     i_bg;
  logic              i_inv_h;
  logic              i_dbl_h;
  logic              o_req_h;
  logic              o_pix_h;
  logic [CW-1:0]     o_rgb;
  logic              o_busy_h;

  vga_pixel_serializer #(
    .FONT_W (FONT_W),
    .GAP_W  (GAP_W),
    .CW     (CW)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_l  (i_rst_l),
    .i_cs_h   (i_cs_h),
    .i_ld_h   (i_ld_h),
    .i_data   (i_data),
    .i_fg     (i_fg),
    .i_bg     (i_bg),
    .i_inv_h  (i_inv_h),
    .i_dbl_h  (i_dbl_h),
    .o_req_h  (o_req_h),
    .o_pix_h  (o_pix_h),
    .o_rgb    (o_rgb),
    .o_busy_h (o_busy_h)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic          busy;
    logic          pix;
    logic [CW-1:0] rgb;
    logic          req;
  } out_t;

  typedef struct packed {
    logic          pix;
    logic [CW-1:0] rgb;
    logic          last;
  } cell_px_t;

  cell_px_t    cell_q[$];
  out_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pix_hist;
  logic [31:0] req_hist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a load expands the whole cell into a list of output pixels.
  task automatic model_load();
    cell_px_t e;
    logic     b;
    cell_q.delete();
    for (int i = 0; i < CELL_W; i++) begin
      b = 1'b0;
      if (i < FONT_W) b = i_data[FONT_W-1-i];
      e.pix  = b ^ i_inv_h;
      e.rgb  = e.pix ? i_fg : i_bg;
      e.last = 1'b0;
      cell_q.push_back(e);
      if (i_dbl_h) cell_q.push_back(e);
    end
    cell_q[cell_q.size()-1].last = 1'b1;
  endtask

  function automatic out_t model_out();
    out_t o;
    o = '0;
    if (i_rst_l && i_cs_h && cell_q.size() > 0) begin
      o.busy = 1'b1;
      o.pix  = cell_q[0].pix;
      o.rgb  = cell_q[0].rgb;
      o.req  = cell_q[0].last;
    end
    return o;
  endfunction

  task automatic tick(input string tag);
    out_t e;
    #1;
    exp_q.push_back(model_out());
    e = exp_q.pop_front();
    check({tag, ".busy"}, 32'(o_busy_h), 32'(e.busy));
    check({tag, ".pix"},  32'(o_pix_h),  32'(e.pix));
    check({tag, ".rgb"},  32'(o_rgb),    32'(e.rgb));
    check({tag, ".req"},  32'(o_req_h),  32'(e.req));
    pix_hist = {pix_hist[30:0], o_pix_h};
    req_hist = {req_hist[30:0], o_req_h};
    @(posedge i_clk);
    if (!i_rst_l) begin
      cell_q.delete();
    end else if (i_cs_h) begin
      if (i_ld_h) model_load();
      else if (cell_q.size() > 0) void'(cell_q.pop_front());
    end
    @(negedge i_clk);
  endtask

  task automatic set_in(input logic cs, input logic ld, input logic [FONT_W-1:0] d,
                        input logic [CW-1:0] fg, input logic [CW-1:0] bg,
                        input logic inv, input logic dbl);
    i_cs_h  = cs;
    i_ld_h  = ld;
    i_data  = d;
    i_fg    = fg;
    i_bg    = bg;
    i_inv_h = inv;
    i_dbl_h = dbl;
  endtask

  initial begin
    int nxt;
    int busy_cnt;
    int first_b;
    int last_b;
    i_rst_l = 1'b0;
    set_in(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    pix_hist = '0;
    req_hist = '0;
    @(negedge i_clk);

    // Reset held, then released with no load
    repeat (3) tick("rst");
    i_rst_l = 1'b1;
    i_cs_h  = 1'b1;
    repeat (4) tick("idle");

    // Basic cell
    set_in(1'b1, 1'b1, 8'hA5, 4'hF, 4'h1, 1'b0, 1'b0);
    tick("basic_ld");
    i_ld_h = 1'b0;
    pix_hist = '0;
    req_hist = '0;
    repeat (10) tick("basic");
    check("basic_pix_seq", 32'(pix_hist[9:0]), 32'(10'b1010010100));
    check("basic_req_seq", 32'(req_hist[9:0]), 32'(10'b0000000001));
    repeat (2) tick("basic_idle");

    // Inverse + double width
    set_in(1'b1, 1'b1, 8'h80, 4'h5, 4'hA, 1'b1, 1'b1);
    tick("invdbl_ld");
    i_ld_h = 1'b0;
    pix_hist = '0;
    req_hist = '0;
    repeat (20) tick("invdbl");
    check("invdbl_pix_seq", 32'(pix_hist[19:0]), 32'(20'h3FFFF));
    check("invdbl_req_seq", 32'(req_hist[19:0]), 32'(20'h00001));
    tick("invdbl_idle");

    // Gapless stream answering o_req_h with loads
    set_in(1'b1, 1'b1, 8'hFF, 4'h3, 4'hC, 1'b0, 1'b0);
    tick("gap_ld");
    nxt = 0;
    busy_cnt = 0;
    first_b = -1;
    last_b = -1;
    for (int c = 0; c < 40; c++) begin
      i_ld_h = 1'b0;
      #1;
      if (o_req_h && nxt < 2) begin
        i_ld_h = 1'b1;
        i_data = (nxt == 0) ? 8'h00 : 8'hFF;
        nxt++;
      end
      if (o_busy_h) begin
        busy_cnt++;
        if (first_b < 0) first_b = c;
        last_b = c;
      end
      tick("gapless");
    end
    check("gapless_busy_cnt", 32'(busy_cnt), 32'd30);
    check("gapless_span", 32'(last_b - first_b + 1), 32'd30);
    check("gapless_loads", 32'(nxt), 32'd2);

    // Enable gaps, then mid-cell load
    set_in(1'b1, 1'b1, 8'hC3, 4'h9, 4'h6, 1'b0, 1'b0);
    tick("cs_ld");
    i_ld_h = 1'b0;
    pix_hist = '0;
    repeat (2) tick("cs_run");
    i_cs_h = 1'b0;
    repeat (3) tick("cs_off");
    i_cs_h = 1'b1;
    repeat (2) tick("cs_resume");
    set_in(1'b1, 1'b1, 8'h3C, 4'h2, 4'hD, 1'b1, 1'b0);
    tick("mid_ld");
    i_ld_h = 1'b0;
    tick("mid_new");
    check("cs_mid_pix_seq", 32'(pix_hist[8:0]), 32'(9'b110000001));
    repeat (10) tick("mid_rest");

    // Async reset during pixel 5
    set_in(1'b1, 1'b1, 8'hFF, 4'h7, 4'h1, 1'b0, 1'b0);
    tick("ar_ld");
    i_ld_h = 1'b0;
    repeat (5) tick("ar_run");
    #2;
    i_rst_l = 1'b0;
    #1;
    check("ar_busy_now", 32'(o_busy_h), 32'd0);
    check("ar_pix_now",  32'(o_pix_h),  32'd0);
    check("ar_rgb_now",  32'(o_rgb),    32'd0);
    check("ar_req_now",  32'(o_req_h),  32'd0);
    tick("ar_hold");
    tick("ar_hold");
    i_rst_l = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (o_busy_h) busy_cnt++;
      tick("ar_post");
    end
    check("ar_post_busy", 32'(busy_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
